// File: rtl/jtag_pkg.sv
// jtag_pkg: shared DMI types and widths for the DTM-side debug bridge
package jtag_pkg;
  localparam int unsigned DMI_DATA_W = 32;
  typedef enum logic [1:0] {
    DMI_OP_SUCCESS = 2'd0,
    DMI_OP_FAILED  = 2'd2,
    DMI_OP_BUSY    = 2'd3
  } dmi_op_e;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} dmi_state_e;
endpackage

// File: rtl/dmi_bus_bridge.sv
// dmi_bus_bridge: turns one DTM DMI request into one req/gnt/rvalid bus access with sticky status
module dmi_bus_bridge
  import jtag_pkg::*;
#(
  parameter int unsigned ABITS     = 7,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned RESP_HOLD = 5
) (
  input  logic                  jtag_tck_i,
  input  logic                  jtag_trstn_i,
  input  logic                  dmi_req_i,
  input  logic                  dmi_we_i,
  input  logic [31:0]           dmi_addr_i,
  input  logic [DMI_DATA_W-1:0] dmi_wdata_i,
  output logic                  dmi_ack_o,
  output logic [1:0]            dmi_op_o,
  output logic [DMI_DATA_W-1:0] dmi_rdata_o,
  output logic                  dmi_rdata_valid_o,
  input  logic                  dtmcs_dmireset_i,
  input  logic                  dtmcs_dmihardreset_i,
  output logic [1:0]            dtmcs_dmistat_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ABITS-1:0]      bus_addr_o,
  output logic [DMI_DATA_W-1:0] bus_wdata_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_rvalid_i,
  input  logic [DMI_DATA_W-1:0] bus_rdata_i,
  input  logic                  bus_err_i
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam int unsigned HW = $clog2(RESP_HOLD + 1);

  dmi_state_e            state_q, state_d;
  dmi_op_e               sticky_q, sticky_d, op_q, op_d;
  logic                  req_q, start;
  logic                  bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [ABITS-1:0]      bus_addr_q, bus_addr_d;
  logic [DMI_DATA_W-1:0] bus_wdata_q, bus_wdata_d, rdata_q, rdata_d;
  logic                  ack_q, ack_d, rvalid_q, rvalid_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [HW-1:0]         hold_q, hold_d;

  assign dmi_ack_o         = ack_q;
  assign dmi_op_o          = op_q;
  assign dmi_rdata_o       = rdata_q;
  assign dmi_rdata_valid_o = rvalid_q;
  assign dtmcs_dmistat_o   = sticky_q;
  assign bus_req_o         = bus_req_q;
  assign bus_we_o          = bus_we_q;
  assign bus_addr_o        = bus_addr_q;
  assign bus_wdata_o       = bus_wdata_q;

  // next-state: access sequencing, response window, sticky status and abort
  always_comb begin
    start       = dmi_req_i & ~req_q;
    state_d     = state_q;
    sticky_d    = sticky_q;
    op_d        = op_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    ack_d       = ack_q;
    rvalid_d    = rvalid_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    case (state_q)
      IDLE: if (start) begin
        if (sticky_q != DMI_OP_SUCCESS || |dmi_addr_i[31:ABITS]) begin
          state_d = RESP;
          ack_d   = 1'b1;
          hold_d  = HW'(RESP_HOLD - 1);
          op_d    = (sticky_q != DMI_OP_SUCCESS) ? sticky_q : DMI_OP_FAILED;
          sticky_d = op_d;
        end else begin
          state_d     = REQ;
          bus_req_d   = 1'b1;
          bus_we_d    = dmi_we_i;
          bus_addr_d  = dmi_addr_i[ABITS-1:0];
          bus_wdata_d = dmi_wdata_i;
          cnt_d       = '0;
        end
      end
      REQ, WAIT: begin
        if (bus_rvalid_i && (state_q == WAIT || bus_gnt_i)) begin
          state_d   = RESP;
          bus_req_d = 1'b0;
          ack_d     = 1'b1;
          hold_d    = HW'(RESP_HOLD - 1);
          op_d      = bus_err_i ? DMI_OP_FAILED : DMI_OP_SUCCESS;
          sticky_d  = bus_err_i ? DMI_OP_FAILED : sticky_q;
          rvalid_d  = ~bus_we_q & ~bus_err_i;
          rdata_d   = rvalid_d ? bus_rdata_i : '0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d   = RESP;
          bus_req_d = 1'b0;
          ack_d     = 1'b1;
          hold_d    = HW'(RESP_HOLD - 1);
          op_d      = DMI_OP_FAILED;
          sticky_d  = DMI_OP_FAILED;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (state_q == REQ && bus_gnt_i) begin
            state_d   = WAIT;
            bus_req_d = 1'b0;
          end
        end
      end
      RESP: if (hold_q == '0) begin
        state_d  = IDLE;
        ack_d    = 1'b0;
        op_d     = DMI_OP_SUCCESS;
        rdata_d  = '0;
        rvalid_d = 1'b0;
      end else begin
        hold_d = hold_q - HW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (start && state_q != IDLE && sticky_d != DMI_OP_FAILED) sticky_d = DMI_OP_BUSY;
    if (dtmcs_dmireset_i) sticky_d = DMI_OP_SUCCESS;
    if (dtmcs_dmihardreset_i) begin
      state_d   = IDLE;
      sticky_d  = DMI_OP_SUCCESS;
      op_d      = DMI_OP_SUCCESS;
      bus_req_d = 1'b0;
      ack_d     = 1'b0;
      rdata_d   = '0;
      rvalid_d  = 1'b0;
      cnt_d     = '0;
      hold_d    = '0;
    end
  end

  // state and registered outputs
  always_ff @(posedge jtag_tck_i or negedge jtag_trstn_i) begin
    if (!jtag_trstn_i) begin
      state_q     <= IDLE;
      sticky_q    <= DMI_OP_SUCCESS;
      op_q        <= DMI_OP_SUCCESS;
      req_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      cnt_q       <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      sticky_q    <= sticky_d;
      op_q        <= op_d;
      req_q       <= dmi_req_i;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      rvalid_q    <= rvalid_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
    end
  end
endmodule

// File: doc/dmi_bus_bridge.md
Name: dmi_bus_bridge

Overview:
DMI target stage directly downstream of the JTAG DTM. It consumes dmi_req/addr/wdata/we from the DTM and performs one access on a simple req/gnt/rvalid register bus toward the debug-module registers. It returns dmi_ack/op/rdata/rdata_valid to the DTM and reports sticky status for dtmcs.dmistat. The block runs in the TCK domain.

Parameters:
ABITS, 7, implemented DMI address width; dmi_addr_i[31:ABITS] must be zero.
TIMEOUT, 64, cycles allowed from bus_req_o rise to bus_rvalid_i before the access fails.
RESP_HOLD, 5, cycles that dmi_ack_o/op/rdata stay driven.

Ports:
jtag_tck_i  in  1  clock
jtag_trstn_i  in  1  async active-low reset
dmi_req_i  in  1  request level from DTM; rising edge starts an access
dmi_we_i  in  1  1=write, 0=read
dmi_addr_i  in  32  DMI address
dmi_wdata_i  in  32  write data
dmi_ack_o  out  1  response strobe, held RESP_HOLD cycles
dmi_op_o  out  2  0 success, 2 failed, 3 busy
dmi_rdata_o  out  32  read data
dmi_rdata_valid_o  out  1  dmi_rdata_o valid (successful read only)
dtmcs_dmireset_i  in  1  pulse: clear sticky status
dtmcs_dmihardreset_i  in  1  pulse: abort access and clear sticky status
dtmcs_dmistat_o  out  2  sticky status to DTM
bus_req_o  out  1  bus request, held until bus_gnt_i
bus_we_o  out  1  bus write
bus_addr_o  out  ABITS  bus address
bus_wdata_o  out  32  bus write data
bus_gnt_i  in  1  request accepted
bus_rvalid_i  in  1  completion (reads and writes)
bus_rdata_i  in  32  read data, valid with bus_rvalid_i
bus_err_i  in  1  error, valid with bus_rvalid_i

Behaviour:
- Clock: jtag_tck_i. Reset: jtag_trstn_i, asynchronous, active-low. Reset values: all outputs 0; FSM=IDLE; sticky=0; counters=0.
- Edge detect: req_q <= dmi_req_i. start = dmi_req_i & ~req_q. A held level never retriggers.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE, start, sticky≠0: go to RESP with op=sticky. No bus access.
- IDLE, start, dmi_addr_i[31:ABITS]≠0: go to RESP with op=2, sticky<=2. No bus access.
- IDLE, start, otherwise: latch we/addr/wdata into the bus_* registers and go to REQ. bus_req_o rises the cycle after the start edge.
- REQ: bus_req_o=1. On bus_gnt_i, deassert bus_req_o next cycle and go to WAIT. bus_gnt_i and bus_rvalid_i in the same cycle count as completion.
- WAIT: on bus_rvalid_i go to RESP.
  - bus_err_i=1: op=2, sticky<=2.
  - bus_err_i=0: op=0. Reads latch bus_rdata_i and set rdata_valid.
- Timeout: a counter runs from bus_req_o rise through REQ/WAIT. At TIMEOUT with no rvalid: go to RESP with op=2, sticky<=2, drop bus_req_o. A late bus_rvalid_i is ignored in IDLE.
- RESP:
  - dmi_ack_o=1 for exactly RESP_HOLD cycles, beginning the cycle after the transition.
  - op, rdata and rdata_valid are stable for the whole window. rdata=0 and rdata_valid=0 unless it is a successful read.
  - After the window, all of these return to 0 and the FSM goes to IDLE.
- Busy: start while not IDLE sets sticky<=3 (unless sticky is already 2). The request is discarded; the current access is unaffected.
- Sticky priority: failed(2) is never overwritten by busy(3). dtmcs_dmistat_o = sticky.
- dtmcs_dmireset_i: sticky<=0. The FSM is unaffected.
- dtmcs_dmihardreset_i: synchronous abort.
  - FSM<=IDLE, sticky<=0, all dmi_*_o and bus_req_o go to 0 next cycle.
  - Takes priority over every other event in that cycle.
- Latency for a zero-wait read (gnt and rvalid one cycle after bus_req_o): start at cycle N → bus_req_o N+1 → dmi_ack_o N+3.

Decomposition:
- Package jtag_pkg:
  - dmi_op_e: DMI_OP_SUCCESS=2'd0, DMI_OP_FAILED=2'd2, DMI_OP_BUSY=2'd3.
  - dmi_state_e: IDLE/REQ/WAIT/RESP.
  - DMI_DATA_W=32.
- Single module. The timeout and hold counters are small and inline; no sub-module is warranted.

Test Plan:
1. Write addr 0x0a, wdata 0x8c, bus gnt+rvalid after 2 cycles → bus_we_o=1, bus_addr_o=0x0a, bus_wdata_o=0x8c; dmi_ack_o high 5 cycles with op=0 and rdata_valid=0; dmistat=0.
2. Read addr 0x12, bus_rdata_i=0x123 → dmi_rdata_o=0x123, rdata_valid=1, op=0 for 5 cycles, then all 0.
3. Read with bus_err_i=1 → op=2, dmistat=2. The next request (addr 0x12) returns op=2 with no bus_req_o. dmireset pulse → dmistat=0; the following read succeeds.
4. Bus never answers → bus_req_o dropped after 64 cycles; op=2; dmistat=2.
5. Second dmi_req_i rising edge during WAIT → dmistat=3; the first access completes with op=0; only one bus_req_o pulse occurs.
6. Address 0x80 (ABITS=7) → immediate op=2 with no bus access. Separately, assert dmihardreset while in REQ → bus_req_o=0 next cycle, FSM IDLE, dmistat=0.
